dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port of the dual-issue pipelined MIPS between the two MEM-stage lanes.
//  Lane 0 is always the older instruction and lane 1 the younger.
//  When both lanes access memory in the same cycle, the block serializes them in program order over two cycles.
//  It raises stall to freeze the pipeline for the extra cycle and holds lane 0's load data until both are done.
//  It drives the memwrite/dataadr/writedata signals seen at the top level.
// PARAMETERS
//  AW  32  address width (byte address)
//  DW  32  data width
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  req0_valid   in   1   lane 0 MEM-stage memory op (lw/sw) present
//  req0_we      in   1   lane 0 is a store
//  req0_addr    in   AW  lane 0 byte address
//  req0_wdata   in   DW  lane 0 store data
//  req1_valid   in   1   lane 1 memory op present
//  req1_we      in   1   lane 1 is a store
//  req1_addr    in   AW  lane 1 byte address
//  req1_wdata   in   DW  lane 1 store data
//  flush        in   1   squash lane 1 (younger-lane kill from branch/jump resolution)
//  mem_readdata in   DW  combinational read data from data memory
//  memwrite     out  1   memory write enable
//  dataadr      out  AW  memory address
//  writedata    out  DW  memory write data
//  rdata0       out  DW  load result to lane 0 writeback
//  rdata1       out  DW  load result to lane 1 writeback
//  stall        out  1   freeze IF..MEM pipeline registers this cycle
// BEHAVIOUR
//  - States: IDLE, SECOND. Reset is asynchronous and active-high: state=IDLE, hold0=0.
//  - While reset is high, all outputs are 0: memwrite, stall, dataadr, writedata, rdata0, rdata1.
//  - IDLE, neither lane valid: memwrite=0, dataadr=0, writedata=0, stall=0, rdata0=rdata1=mem_readdata. Stay IDLE.
//  - IDLE, exactly one lane valid: drive that lane's addr/wdata and memwrite=reqX_we.
//    The matching rdataX=mem_readdata in the same cycle (zero latency); stall=0; stay IDLE.
//  - IDLE, both valid, flush=0: drive lane 0 and assert stall=1.
//    hold0<=mem_readdata at the clock edge; next state SECOND.
//  - IDLE, both valid, flush=1: lane 1 is squashed. Serve lane 0 only, stall=0, stay IDLE.
//  - SECOND: pipeline inputs are frozen, so the req1_* signals are unchanged.
//    Drive lane 1 with memwrite=req1_we, rdata1=mem_readdata, rdata0=hold0, stall=0.
//    Next state is IDLE unconditionally.
//  - SECOND with flush=1: memwrite=0, dataadr=0, writedata=0; lane 1 op dropped.
//    rdata0=hold0, stall=0, next IDLE.
//  - Ordering: lane 0 always precedes lane 1.
//    Store(lane0)->load(lane1) to the same address returns the new data. No forwarding is needed.
//  - Lane 0 store + lane 1 store to the same address: memory ends with lane 1 data.
//  - A stall lasts at most 1 cycle per bundle; stall is never asserted in SECOND.
//  - Reset asserted in SECOND aborts the lane 1 access immediately (memwrite=0 combinationally).
//  - Addresses are passed unmodified; alignment is not checked. Data width equals DW; no byte enables.
// STRUCTURE
//  - Shared header mips_defs.vh holds: state encodings (ARB_IDLE=1'b0, ARB_SECOND=1'b1), AW/DW defaults.
//  - Sub-module: flopenr (existing enable+async-reset register) for hold0, enabled on IDLE&both-valid&~flush.
//  - Remainder is one state flop plus a combinational mux/decode; no other hierarchy.
// TESTING
//  - Lane0 sw addr 84 data 7, lane1 idle -> same cycle memwrite=1, dataadr=84, writedata=7, stall=0.
//  - Lane0 sw 80<-5, lane1 sw 84<-7 -> cycle1: addr 80, data 5, stall=1.
//    cycle2: addr 84, data 7, stall=0; then IDLE.
//  - Lane0 sw 84<-7, lane1 lw 84 -> cycle1 write, stall=1; cycle2 memwrite=0, rdata1=7.
//  - Lane0 lw 0 (mem=0x11), lane1 lw 4 (mem=0x22) -> cycle2 rdata0=0x11 (held), rdata1=0x22.
//  - Both valid, flush=1 in cycle2 with lane1 sw 88<-9 -> cycle2 memwrite=0, mem[88] unchanged, state IDLE.
//  - Reset asserted mid-SECOND -> memwrite, stall, rdata0 all 0 at once.
//    After release, a lane0-only op completes in 1 cycle.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | dmem_port_arbiter_pkg : shared types/defaults for the dmem arbiter|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package dmem_port_arbiter_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// +------------------------------------------------------------------+
// | dmem_port_arbiter_if : MEM-stage lanes <-> arbiter <-> data memory|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          flush;
  logic [DW-1:0] mem_readdata;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          stall;

  // Pipeline and memory side together drive the requests and read data
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output flush, mem_readdata,
    input  memwrite, dataadr, writedata, rdata0, rdata1, stall
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  flush, mem_readdata,
    output memwrite, dataadr, writedata, rdata0, rdata1, stall
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter_flopenr.sv
// +------------------------------------------------------------------+
// | flopenr : enabled register with asynchronous active-high reset    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// +------------------------------------------------------------------+
// | dmem_port_arbiter : serializes two MEM lanes onto one dmem port   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus
);

  arb_state_t    state;
  arb_state_t    state_next;
  logic          both_valid;
  logic          hold_en;
  logic [DW-1:0] hold0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
  logic          stall_c;

  assign both_valid = bus.req0_valid & bus.req1_valid;
  assign hold_en    = (state == ARB_IDLE) & both_valid & ~bus.flush;

  flopenr #(.WIDTH(DW)) u_hold0 (
    .clk   (clk),
    .reset (reset),
    .en    (hold_en),
    .d     (bus.mem_readdata),
    .q     (hold0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = ARB_IDLE;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall_c    = 1'b0;
    rd0        = bus.mem_readdata;
    rd1        = bus.mem_readdata;
    if (reset) begin
      // Outputs are forced low the moment reset rises, aborting any lane 1 access
      rd0 = '0;
      rd1 = '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (bus.req0_valid) begin
            mem_we    = bus.req0_we;
            mem_addr  = bus.req0_addr;
            mem_wdata = bus.req0_wdata;
            if (bus.req1_valid && !bus.flush) begin
              stall_c    = 1'b1;
              state_next = ARB_SECOND;
            end
          end else if (bus.req1_valid && !bus.flush) begin
            // A flushed younger op is never allowed to touch memory
            mem_we    = bus.req1_we;
            mem_addr  = bus.req1_addr;
            mem_wdata = bus.req1_wdata;
          end
        end
        ARB_SECOND: begin
          rd0 = hold0;
          if (!bus.flush) begin
            mem_we    = bus.req1_we;
            mem_addr  = bus.req1_addr;
            mem_wdata = bus.req1_wdata;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  assign bus.memwrite  = mem_we;
  assign bus.dataadr   = mem_addr;
  assign bus.writedata = mem_wdata;
  assign bus.rdata0    = rd0;
  assign bus.rdata1    = rd1;
  assign bus.stall     = stall_c;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// +------------------------------------------------------------------+
// | tb_dmem_port_arbiter : directed self-checking bench for the arbiter|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mem [0:63];

  dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed data memory: combinational read, clocked write
  assign bus.mem_readdata = mem[bus.dataadr[7:2]];
  always @(posedge clk) if (bus.memwrite) mem[bus.dataadr[7:2]] <= bus.writedata;

  task automatic drive(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic fl);
    bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
    bus.flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'd84, 32'd7, 1, 1, 32'd88, 32'd9, 0);
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %0h exp 0", bus.memwrite); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", bus.stall); end
    checks++; if (bus.dataadr !== 32'd0) begin errors++; $display("FAIL reset_dataadr got %0h exp 0", bus.dataadr); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata got %0h exp 0", bus.writedata); end
    checks++; if (bus.rdata0 !== 32'd0 || bus.rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata got %0h/%0h exp 0/0", bus.rdata0, bus.rdata1); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b0 || bus.dataadr !== 32'd0 || bus.stall !== 1'b0) begin errors++; $display("FAIL idle_outputs got we=%0h adr=%0h st=%0h exp 0/0/0", bus.memwrite, bus.dataadr, bus.stall); end
    checks++; if (bus.rdata0 !== 32'h11) begin errors++; $display("FAIL idle_rdata0 got %0h exp 11", bus.rdata0); end
    next_cycle();
  endtask

  task automatic test_single_store();
    drive(1, 1, 32'd84, 32'd7, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b1) begin errors++; $display("FAIL single_memwrite got %0h exp 1", bus.memwrite); end
    checks++; if (bus.dataadr !== 32'd84) begin errors++; $display("FAIL single_dataadr got %0d exp 84", bus.dataadr); end
    checks++; if (bus.writedata !== 32'd7) begin errors++; $display("FAIL single_writedata got %0d exp 7", bus.writedata); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL single_stall got %0h exp 0", bus.stall); end
    next_cycle();
    drive(1, 0, 32'd84, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata0 !== 32'd7) begin errors++; $display("FAIL single_readback got %0d exp 7", bus.rdata0); end
    next_cycle();
  endtask

  task automatic test_back_to_back_stores();
    drive(1, 1, 32'd80, 32'd5, 1, 1, 32'd84, 32'd8, 0);
    @(negedge clk);
    checks++; if (bus.dataadr !== 32'd80 || bus.writedata !== 32'd5 || bus.memwrite !== 1'b1) begin errors++; $display("FAIL b2b_c1_bus got adr=%0d dat=%0d we=%0h exp 80/5/1", bus.dataadr, bus.writedata, bus.memwrite); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_c1_stall got %0h exp 1", bus.stall); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.dataadr !== 32'd84 || bus.writedata !== 32'd8 || bus.memwrite !== 1'b1) begin errors++; $display("FAIL b2b_c2_bus got adr=%0d dat=%0d we=%0h exp 84/8/1", bus.dataadr, bus.writedata, bus.memwrite); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_c2_stall got %0h exp 0", bus.stall); end
    next_cycle();
    drive(1, 0, 32'd80, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0 || bus.rdata0 !== 32'd5) begin errors++; $display("FAIL b2b_after got st=%0h rd0=%0d exp 0/5", bus.stall, bus.rdata0); end
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 32'd84, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata1 !== 32'd8 || bus.stall !== 1'b0) begin errors++; $display("FAIL lane1_only_read got rd1=%0d st=%0h exp 8/0", bus.rdata1, bus.stall); end
    next_cycle();
  endtask

  task automatic test_store_then_load();
    drive(1, 1, 32'd92, 32'd7, 1, 0, 32'd92, 0, 0);
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b1 || bus.stall !== 1'b1) begin errors++; $display("FAIL stld_c1 got we=%0h st=%0h exp 1/1", bus.memwrite, bus.stall); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b0 || bus.dataadr !== 32'd92) begin errors++; $display("FAIL stld_c2_bus got we=%0h adr=%0d exp 0/92", bus.memwrite, bus.dataadr); end
    checks++; if (bus.rdata1 !== 32'd7) begin errors++; $display("FAIL stld_rdata1 got %0d exp 7", bus.rdata1); end
    next_cycle();
  endtask

  task automatic test_load_load();
    drive(1, 0, 32'd0, 0, 1, 0, 32'd4, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata0 !== 32'h11 || bus.stall !== 1'b1) begin errors++; $display("FAIL ldld_c1 got rd0=%0h st=%0h exp 11/1", bus.rdata0, bus.stall); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rdata0 !== 32'h11) begin errors++; $display("FAIL ldld_hold0 got %0h exp 11", bus.rdata0); end
    checks++; if (bus.rdata1 !== 32'h22) begin errors++; $display("FAIL ldld_rdata1 got %0h exp 22", bus.rdata1); end
    next_cycle();
  endtask

  task automatic test_same_addr_stores();
    drive(1, 1, 32'd96, 32'd1, 1, 1, 32'd96, 32'd2, 0);
    next_cycle();
    next_cycle();
    drive(1, 0, 32'd96, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata0 !== 32'd2) begin errors++; $display("FAIL same_addr_final got %0d exp 2", bus.rdata0); end
    next_cycle();
  endtask

  task automatic test_flush_idle();
    drive(1, 1, 32'd100, 32'd3, 1, 1, 32'd104, 32'd4, 1);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0 || bus.dataadr !== 32'd100 || bus.memwrite !== 1'b1) begin errors++; $display("FAIL flush_idle got st=%0h adr=%0d we=%0h exp 0/100/1", bus.stall, bus.dataadr, bus.memwrite); end
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 32'd104, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata1 !== 32'd0 || bus.stall !== 1'b0) begin errors++; $display("FAIL flush_idle_mem104 got rd1=%0d st=%0h exp 0/0", bus.rdata1, bus.stall); end
    next_cycle();
  endtask

  task automatic test_flush_second();
    drive(1, 0, 32'd0, 0, 1, 1, 32'd88, 32'd9, 0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush2_c1_stall got %0h exp 1", bus.stall); end
    next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b0 || bus.dataadr !== 32'd0 || bus.writedata !== 32'd0) begin errors++; $display("FAIL flush2_c2_bus got we=%0h adr=%0d dat=%0d exp 0/0/0", bus.memwrite, bus.dataadr, bus.writedata); end
    checks++; if (bus.rdata0 !== 32'h11 || bus.stall !== 1'b0) begin errors++; $display("FAIL flush2_c2_rd0 got rd0=%0h st=%0h exp 11/0", bus.rdata0, bus.stall); end
    next_cycle();
    drive(1, 0, 32'd88, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata0 !== 32'd0 || bus.stall !== 1'b0) begin errors++; $display("FAIL flush2_mem88 got rd0=%0d st=%0h exp 0/0", bus.rdata0, bus.stall); end
    next_cycle();
  endtask

  task automatic test_reset_mid_second();
    drive(1, 0, 32'd4, 0, 1, 1, 32'd108, 32'd5, 0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rstmid_c1_stall got %0h exp 1", bus.stall); end
    next_cycle();
    reset = 1'b1;
    #1;
    checks++; if (bus.memwrite !== 1'b0 || bus.stall !== 1'b0 || bus.rdata0 !== 32'd0) begin errors++; $display("FAIL rstmid_abort got we=%0h st=%0h rd0=%0h exp 0/0/0", bus.memwrite, bus.stall, bus.rdata0); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    drive(1, 1, 32'd108, 32'd6, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.memwrite !== 1'b1 || bus.stall !== 1'b0 || bus.dataadr !== 32'd108) begin errors++; $display("FAIL rstmid_after got we=%0h st=%0h adr=%0d exp 1/0/108", bus.memwrite, bus.stall, bus.dataadr); end
    next_cycle();
    drive(1, 0, 32'd108, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.rdata0 !== 32'd6) begin errors++; $display("FAIL rstmid_mem108 got %0d exp 6", bus.rdata0); end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    reset = 1'b1;
    test_reset();
    test_single_store();
    test_back_to_back_stores();
    test_store_then_load();
    test_load_load();
    test_same_addr_stores();
    test_flush_idle();
    test_flush_second();
    test_reset_mid_second();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
